// File: rtl/mult_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: flattened operand slices in,
// one-hot grant/ack and the shared product/error back out.
interface mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 3
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] mr_in;
  logic [N_REQ*W-1:0] md_in;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   ack;
  logic [2*W-1:0]     result;
  logic               err;

  modport master (output req, mr_in, md_in, input gnt, ack, result, err);
  modport slave  (input req, mr_in, md_in, output gnt, ack, result, err);
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one shift-add multiplier among N_REQ requesters.
// Optional wait-for-done watchdog enabled by defining MULT_TIMEOUT_EN.
module mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 3,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_arbiter_if.slave  bus,
  output logic           busy,
  output logic           m_init,
  output logic [W-1:0]   m_mr,
  output logic [W-1:0]   m_md,
  input  logic [2*W-1:0] m_pp,
  input  logic           m_done
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, START, ARM, WAIT, DONE} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    ptr, ptr_n, sel;
  logic             found;
  logic [N_REQ-1:0] gnt, gnt_n, ack, ack_n;
  logic [2*W-1:0]   result, result_n;
  logic             busy_n, m_init_n;
  logic [W-1:0]     m_mr_n, m_md_n;
`ifdef MULT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]    cnt, cnt_n;
  logic             err, err_n;
`endif

  function automatic logic [PW-1:0] wrap(input int unsigned v);
    return (v >= N_REQ) ? PW'(v - N_REQ) : PW'(v);
  endfunction

  // Search starts one past the last winner, so the last winner ranks lowest.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!found && bus.req[wrap(32'(ptr) + k)]) begin
        found = 1'b1;
        sel   = wrap(32'(ptr) + k);
      end
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    gnt_n    = gnt;
    ack_n    = '0;
    result_n = result;
    m_init_n = 1'b0;
    m_mr_n   = m_mr;
    m_md_n   = m_md;
`ifdef MULT_TIMEOUT_EN
    cnt_n    = cnt;
    err_n    = err;
`endif
    case (state)
      IDLE: if (found) begin
        state_n  = START;
        ptr_n    = sel;
        gnt_n    = N_REQ'(1) << sel;
        m_mr_n   = bus.mr_in[32'(sel)*W +: W];
        m_md_n   = bus.md_in[32'(sel)*W +: W];
        m_init_n = 1'b1;
      end
      START: begin
        state_n = ARM;
`ifdef MULT_TIMEOUT_EN
        cnt_n   = '0;
`endif
      end
      // A done left over from the previous product is still visible here.
      ARM: begin
        state_n = WAIT;
`ifdef MULT_TIMEOUT_EN
        cnt_n   = cnt + 1'b1;
`endif
      end
      WAIT: begin
        if (m_done) begin
          state_n  = DONE;
          result_n = m_pp;
          ack_n    = gnt;
`ifdef MULT_TIMEOUT_EN
          err_n    = 1'b0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n  = DONE;
          result_n = '0;
          ack_n    = gnt;
          err_n    = 1'b1;
        end else begin
          cnt_n    = cnt + 1'b1;
`endif
        end
      end
      DONE: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= PW'(N_REQ - 1);
      gnt    <= '0;
      ack    <= '0;
      result <= '0;
      busy   <= 1'b0;
      m_init <= 1'b0;
      m_mr   <= '0;
      m_md   <= '0;
`ifdef MULT_TIMEOUT_EN
      cnt    <= '0;
      err    <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      gnt    <= gnt_n;
      ack    <= ack_n;
      result <= result_n;
      busy   <= busy_n;
      m_init <= m_init_n;
      m_mr   <= m_mr_n;
      m_md   <= m_md_n;
`ifdef MULT_TIMEOUT_EN
      cnt    <= cnt_n;
      err    <= err_n;
`endif
    end
  end

  assign bus.gnt    = gnt;
  assign bus.ack    = ack;
  assign bus.result = result;
`ifdef MULT_TIMEOUT_EN
  assign bus.err    = err;
`else
  assign bus.err    = 1'b0;
`endif
endmodule
